// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : AES word types, forward S-box table and round-constant helpers.
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Only indices 1..7 are meaningful for AES-256; everything else yields zero.
  function automatic word_t rcon(input logic [3:0] idx);
    byte_t rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : combinational AES forward S-box, one byte in, one byte out.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = SBOX[data_i];

endmodule

`default_nettype wire

// File: rtl/key_expansion.sv
// ============================================================================
// key_expansion : one AES-256 key-schedule step, w[i..i+7] -> w[i+8..i+15].
// KEYEXP_MSB_PIPE_EN adds a register stage in front of the MSB half. Rev 1.0
// ============================================================================
`default_nettype none

module key_expansion
  import aes_pkg::*;
(
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iEn,
  input  logic [0:255] iKey,
  input  logic [3:0]   cnt_rcon,
  output logic [0:127] oLSB_Key,
  output logic [0:127] oMSB_Key
);

  word_t        k_w [8];
  word_t        lsb_n [4];
  word_t        msb_n [4];
  word_t        msb_k [4];
  word_t        rot_k7;
  word_t        sub_lsb;
  word_t        sub_msb;
  word_t        msb_n3;
  logic [127:0] lsb_d;
  logic [127:0] msb_d;
  logic [127:0] lsb_q;
  logic [127:0] msb_q;

  // Word 0 sits at the low (MSB-first) end of the key bus.
  for (genvar g = 0; g < 8; g++) begin : g_split
    assign k_w[g] = iKey[32*g +: 32];
  end

  assign rot_k7 = rot_word(k_w[7]);

  for (genvar b = 0; b < 4; b++) begin : g_lsb_sbox
    aes_sbox u_sbox (
      .data_i (rot_k7[8*b +: 8]),
      .data_o (sub_lsb[8*b +: 8])
    );
  end

  for (genvar b = 0; b < 4; b++) begin : g_msb_sbox
    aes_sbox u_sbox (
      .data_i (msb_n3[8*b +: 8]),
      .data_o (sub_msb[8*b +: 8])
    );
  end

  always_comb begin
    lsb_n[0] = k_w[0] ^ sub_lsb ^ rcon(cnt_rcon);
    lsb_n[1] = k_w[1] ^ lsb_n[0];
    lsb_n[2] = k_w[2] ^ lsb_n[1];
    lsb_n[3] = k_w[3] ^ lsb_n[2];
    lsb_d    = {lsb_n[0], lsb_n[1], lsb_n[2], lsb_n[3]};
  end

  // Kept apart from the LSB chain so the n3 -> S-box -> n4 path is not a block-level loop.
  always_comb begin
    msb_n[0] = msb_k[0] ^ sub_msb;
    msb_n[1] = msb_k[1] ^ msb_n[0];
    msb_n[2] = msb_k[2] ^ msb_n[1];
    msb_n[3] = msb_k[3] ^ msb_n[2];
    msb_d    = {msb_n[0], msb_n[1], msb_n[2], msb_n[3]};
  end

`ifdef KEYEXP_MSB_PIPE_EN
  word_t        n3_q;
  logic [127:0] khi_q;

  always_ff @(posedge iClk or posedge iRst_n) begin
    if (iRst_n) begin
      n3_q  <= '0;
      khi_q <= '0;
    end else if (iEn) begin
      n3_q  <= lsb_n[3];
      khi_q <= {k_w[4], k_w[5], k_w[6], k_w[7]};
    end
  end

  assign msb_n3 = n3_q;

  for (genvar g = 0; g < 4; g++) begin : g_msb_src
    assign msb_k[g] = khi_q[127-32*g -: 32];
  end
`else
  assign msb_n3 = lsb_n[3];

  for (genvar g = 0; g < 4; g++) begin : g_msb_src
    assign msb_k[g] = k_w[4+g];
  end
`endif

  always_ff @(posedge iClk or posedge iRst_n) begin
    if (iRst_n) begin
      lsb_q <= '0;
      msb_q <= '0;
    end else if (iEn) begin
      lsb_q <= lsb_d;
      msb_q <= msb_d;
    end
  end

  assign oLSB_Key = lsb_q;
  assign oMSB_Key = msb_q;

endmodule

`default_nettype wire

// File: tb/tb_key_expansion.sv
// ============================================================================
// tb_key_expansion : self-checking bench for key_expansion against a FIPS-197
// style key-schedule model with an S-box derived from GF(2^8) inversion. Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_expansion;

`ifdef KEYEXP_MSB_PIPE_EN
  localparam int MSB_LAT = 2;
`else
  localparam int MSB_LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic         en;
  logic [0:255] key;
  logic [3:0]   rc;
  logic [0:127] lsb;
  logic [0:127] msb;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb_tab [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_expansion dut (
    .iClk     (clk),
    .iRst_n   (rst),
    .iEn      (en),
    .iKey     (key),
    .cnt_rcon (rc),
    .oLSB_Key (lsb),
    .oMSB_Key (msb)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    repeat (254) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  function automatic logic [255:0] model_step(input logic [255:0] k, input logic [3:0] c);
    logic [31:0] w [16];
    logic [31:0] t;
    logic [7:0]  r;
    if (c >= 4'd1 && c <= 4'd7) r = 8'h01 << (c - 4'd1);
    else                        r = 8'h00;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 16; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {r, 24'h0};
      else if (i % 8 == 4) t = subw(t);
      w[i] = w[i-8] ^ t;
    end
    return {w[8], w[9], w[10], w[11], w[12], w[13], w[14], w[15]};
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives one step and captures each half once its latency has elapsed;
  // got_m0 is oMSB_Key one edge in (the stale half in the pipelined build).
  task automatic apply_step(input logic [255:0] k, input logic [3:0] c,
                            output logic [127:0] got_l, output logic [127:0] got_m,
                            output logic [127:0] got_m0);
    @(negedge clk);
    en  = 1'b1;
    key = k;
    rc  = c;
    @(posedge clk);
    #1;
    got_l  = lsb;
    got_m0 = msb;
    if (MSB_LAT == 2) begin
      @(posedge clk);
      #1;
    end
    got_m = msb;
    @(negedge clk);
    en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    key = rand_key();
    rc  = 4'd1;
    #2;
    n_checks++; if (lsb !== 128'h0) $display("FAIL reset_lsb got=%h exp=0", lsb); else n_pass++;
    n_checks++; if (msb !== 128'h0) $display("FAIL reset_msb got=%h exp=0", msb); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (lsb !== 128'h0) $display("FAIL reset_en_lsb got=%h exp=0", lsb); else n_pass++;
    n_checks++; if (msb !== 128'h0) $display("FAIL reset_en_msb got=%h exp=0", msb); else n_pass++;
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_known_vectors();
    logic [255:0] kin  [4];
    logic [3:0]   cin  [4];
    logic [255:0] kexp [4];
    logic [127:0] gl, gm, gm0;
    kin[0]  = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    cin[0]  = 4'd1;
    kexp[0] = 256'h9ba35411_8e6925af_a51a8b5f_2067fcde_a8b09c1a_93d194cd_be49846e_b75d5b9a;
    kin[1]  = kexp[0];  // feedback of the previous step's outputs
    cin[1]  = 4'd2;
    kexp[1] = 256'hd59aecb8_5bf3c917_fee94248_de8ebe96_b5a9328a_2678a647_98312229_2f6c79b3;
    kin[2]  = 256'h0;
    cin[2]  = 4'd1;
    kexp[2] = 256'h62636363_62636363_62636363_62636363_aafbfbfb_aafbfbfb_aafbfbfb_aafbfbfb;
    kin[3]  = 256'h0;
    cin[3]  = 4'd0;
    kexp[3] = 256'h63636363_63636363_63636363_63636363_fbfbfbfb_fbfbfbfb_fbfbfbfb_fbfbfbfb;
    for (int i = 0; i < 4; i++) begin
      apply_step(kin[i], cin[i], gl, gm, gm0);
      n_checks++; if (gl !== kexp[i][255:128]) $display("FAIL vec%0d_lsb got=%h exp=%h", i, gl, kexp[i][255:128]); else n_pass++;
      n_checks++; if (gm !== kexp[i][127:0])   $display("FAIL vec%0d_msb got=%h exp=%h", i, gm, kexp[i][127:0]); else n_pass++;
`ifdef KEYEXP_MSB_PIPE_EN
      if (i > 0) begin
        n_checks++; if (gm0 !== kexp[i-1][127:0]) $display("FAIL vec%0d_msb_lag got=%h exp=%h", i, gm0, kexp[i-1][127:0]); else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_hold_and_async_reset();
    logic [255:0] k, e;
    logic [3:0]   c;
    logic [127:0] gl, gm, gm0;
    k = rand_key();
    c = 4'($urandom_range(1, 7));
    e = model_step(k, c);
    apply_step(k, c, gl, gm, gm0);
    n_checks++; if (gl !== e[255:128]) $display("FAIL hold_load_lsb got=%h exp=%h", gl, e[255:128]); else n_pass++;
    n_checks++; if (gm !== e[127:0])   $display("FAIL hold_load_msb got=%h exp=%h", gm, e[127:0]); else n_pass++;
    key = rand_key();
    rc  = 4'($urandom_range(0, 15));
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (lsb !== e[255:128]) $display("FAIL hold_lsb got=%h exp=%h", lsb, e[255:128]); else n_pass++;
    n_checks++; if (msb !== e[127:0])   $display("FAIL hold_msb got=%h exp=%h", msb, e[127:0]); else n_pass++;
    // Assert reset between edges; outputs must clear before any further clock edge.
    #1;
    en  = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (lsb !== 128'h0) $display("FAIL async_rst_lsb got=%h exp=0", lsb); else n_pass++;
    n_checks++; if (msb !== 128'h0) $display("FAIL async_rst_msb got=%h exp=0", msb); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    k = rand_key();
    c = 4'($urandom_range(0, 15));
    e = model_step(k, c);
    apply_step(k, c, gl, gm, gm0);
    n_checks++; if (gl !== e[255:128]) $display("FAIL post_rst_lsb got=%h exp=%h", gl, e[255:128]); else n_pass++;
    n_checks++; if (gm !== e[127:0])   $display("FAIL post_rst_msb got=%h exp=%h", gm, e[127:0]); else n_pass++;
  endtask

  task automatic test_rcon_range();
    logic [255:0] k, e;
    logic [127:0] gl, gm, gm0;
    for (int c = 0; c < 16; c++) begin
      k = rand_key();
      e = model_step(k, 4'(c));
      apply_step(k, 4'(c), gl, gm, gm0);
      n_checks++; if (gl !== e[255:128]) $display("FAIL rcon%0d_lsb got=%h exp=%h", c, gl, e[255:128]); else n_pass++;
      n_checks++; if (gm !== e[127:0])   $display("FAIL rcon%0d_msb got=%h exp=%h", c, gm, e[127:0]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back_chain();
    logic [255:0] k, e;
    logic [127:0] gl, gm, gm0;
    k = rand_key();
    for (int s = 1; s <= 7; s++) begin
      e = model_step(k, 4'(s));
      apply_step(k, 4'(s), gl, gm, gm0);
      n_checks++; if (gl !== e[255:128]) $display("FAIL chain%0d_lsb got=%h exp=%h", s, gl, e[255:128]); else n_pass++;
      n_checks++; if (gm !== e[127:0])   $display("FAIL chain%0d_msb got=%h exp=%h", s, gm, e[127:0]); else n_pass++;
      k = e;
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    key = '0;
    rc  = 4'd0;
    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));
    test_reset();
    test_known_vectors();
    test_hold_and_async_reset();
    test_rcon_range();
    test_back_to_back_chain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
